// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 8;

  // Index width for a requester number; never zero so a single requester still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin winner selection: scans from last_owner+1 upward with wrap,
// returns a one-hot winner and a flag saying anyone was requesting.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_owner_i,
  output logic [NREQ-1:0] win_o,
  output logic            valid_o
);

  logic [IW-1:0] cand;

  // First requester found after last_owner wins; the scan ends back on last_owner itself.
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_owner_i) + i) % NREQ);
      if (!valid_o && req_i[cand]) begin
        win_o[cand] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Arbitrates NREQ bursting writers onto one FIFO write port.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; pick a round-robin winner and register it as grant
//   BURST | owner streams beats while not full; leaves on last or burst cap
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  input  logic [NREQ-1:0]    req_last_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic               full_i,
  output logic               wr_en_o,
  output logic [DW-1:0]      data_o,
  output logic [NREQ-1:0]    grant_o,
  output logic               busy_o
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_owner_q, last_owner_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [NREQ-1:0] pick_win;
  logic            pick_valid;
  logic [IW-1:0]   owner_idx;
  logic            own_valid;
  logic            own_last;
  logic            xfer;
  logic [CW-1:0]   beat_cnt_inc;
  logic            burst_done;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i        (req_valid_i),
    .last_owner_i (last_owner_q),
    .win_o        (pick_win),
    .valid_o      (pick_valid)
  );

  // Binary index of the current owner, needed to update last_owner on release.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) owner_idx = IW'(i);
    end
  end

  assign own_valid    = |(req_valid_i & grant_q);
  assign own_last     = |(req_last_i & grant_q);
  // Reset gates the transfer so a burst aborted by rst never writes in that cycle.
  assign xfer         = ~rst & (state_q == BURST) & own_valid & ~full_i;
  assign beat_cnt_inc = beat_cnt_q + 1'b1;
  assign burst_done   = xfer & (own_last | (beat_cnt_inc == CW'(MAX_BURST)));

  // Next-state logic for arbitration, burst tracking and owner history.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = BURST;
          grant_d    = pick_win;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_inc;
          if (burst_done) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_idx;
            beat_cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_owner_q <= IW'(NREQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Write-port mux: owner data only on a transfer, zero otherwise.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (xfer && grant_q[k]) data_o = req_data_i[k*DW +: DW];
    end
  end

  assign wr_en_o     = xfer;
  assign req_ready_o = xfer ? grant_q : '0;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 8;
  localparam int LB_DEPTH  = 2;

  logic               clk = 1'b0;
  logic               rclk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ*DW-1:0] req_data_i;
  logic [NREQ-1:0]    req_last_i;
  logic [NREQ-1:0]    req_ready_o;
  logic               full_i;
  logic               wr_en_o;
  logic [DW-1:0]      data_o;
  logic [NREQ-1:0]    grant_o;
  logic               busy_o;

  logic               v [NREQ];
  logic               l [NREQ];
  logic [DW-1:0]      d [NREQ];
  logic               full_drv;
  logic               lb_mode;
  int                 wr_ptr = 0;
  int                 rd_ptr = 0;
  logic [DW-1:0]      lb_mem [LB_DEPTH];
  int                 rb_data [16];
  int                 lb_exp [8] = '{'h80, 'h81, 'h90, 'h91, 'h82, 'h83, 'h92, 'h93};

  int exp_q [$];
  int gnt_q [$];
  int vectors = 0;
  int miscompares = 0;

  fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .full_i      (full_i),
    .wr_en_o     (wr_en_o),
    .data_o      (data_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;
  always #8 rclk = ~rclk;

  always_comb begin
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_valid_i[k]          = v[k];
      req_last_i[k]           = l[k];
      req_data_i[k*DW +: DW]  = d[k];
    end
    full_i = lb_mode ? ((wr_ptr - rd_ptr) >= LB_DEPTH) : full_drv;
  end

  // Behavioural FIFO for the loopback run: write side on clk, read side on rclk.
  always @(posedge clk) begin
    if (lb_mode && wr_en_o) begin
      lb_mem[wr_ptr % LB_DEPTH] <= data_o;
      wr_ptr <= wr_ptr + 1;
    end
  end

  always @(posedge rclk) begin
    if (lb_mode && (wr_ptr != rd_ptr) && (rd_ptr < 16)) begin
      rb_data[rd_ptr] <= int'(lb_mem[rd_ptr % LB_DEPTH]);
      rd_ptr <= rd_ptr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void exp_beats(input int k, input int n, input int base);
    for (int i = 0; i < n; i++) exp_q.push_back((k << 8) | (base + i));
  endfunction

  // Monitor: pops the scoreboard on every write and on every new grant.
  task automatic monitor();
    logic [NREQ-1:0] prev_g = '0;
    logic [NREQ-1:0] oh;
    int e;
    int g;
    forever begin
      @(negedge clk);
      if (full_i) chk("write_while_full", 32'(wr_en_o), 0);
      if (wr_en_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(data_o), 32'hFFFF);
        end else begin
          e  = exp_q.pop_front();
          oh = '0;
          oh[e[9:8]] = 1'b1;
          chk("wr_data", 32'(data_o), 32'(e & 'hFF));
          chk("wr_ready", 32'(req_ready_o), 32'(oh));
        end
      end else begin
        chk("idle_data_zero", 32'(data_o), 0);
        chk("idle_ready_zero", 32'(req_ready_o), 0);
      end
      chk("busy_vs_grant", 32'(busy_o), 32'(grant_o != '0));
      if (grant_o != '0 && grant_o != prev_g) begin
        chk("grant_gap", 32'(prev_g), 0);
        if (gnt_q.size() == 0) begin
          chk("unexpected_grant", 32'(grant_o), 0);
        end else begin
          g = gnt_q.pop_front();
          chk("grant_order", 32'(grant_o), 32'(1) << g);
        end
      end
      prev_g = grant_o;
    end
  endtask

  // Presents n beats on requester k, stepping to the next beat after each accept.
  task automatic send(input int k, input int n, input int base, input bit with_last);
    int waited;
    for (int i = 0; i < n; i++) begin
      v[k] = 1'b1;
      d[k] = DW'(base + i);
      l[k] = with_last && (i == n - 1);
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!req_ready_o[k] && waited < 400);
      if (!req_ready_o[k]) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout req%0d beat %0d: ready 0 after %0d cycles, expected 1", k, i, waited);
        v[k] = 1'b0;
        l[k] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    v[k] = 1'b0;
    l[k] = 1'b0;
    d[k] = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int t;
    for (int k = 0; k < NREQ; k++) begin
      v[k] = 1'b0;
      l[k] = 1'b0;
      d[k] = '0;
    end
    rst      = 1'b1;
    full_drv = 1'b0;
    lb_mode  = 1'b0;
    fork
      monitor();
    join_none

    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_wr_en", 32'(wr_en_o), 0);
    @(posedge clk); #1 rst = 1'b0;

    // single 3-beat burst from req0
    exp_beats(0, 3, 'h10);
    gnt_q.push_back(0);
    fork
      send(0, 3, 'h10, 1'b1);
      begin
        @(negedge clk);
        chk("s1_arb_cycle_grant", 32'(grant_o), 0);
        chk("s1_arb_cycle_wr", 32'(wr_en_o), 0);
        @(negedge clk);
        chk("s1_grant", 32'(grant_o), 1);
        chk("s1_wr_en", 32'(wr_en_o), 1);
      end
    join
    @(negedge clk);
    chk("s1_back_idle", 32'(busy_o), 0);

    // round robin 0,1,2,3,0 from fresh reset
    pulse_reset();
    exp_q.push_back('h020); exp_q.push_back('h121); exp_q.push_back('h222);
    exp_q.push_back('h323); exp_q.push_back('h024);
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2);
    gnt_q.push_back(3); gnt_q.push_back(0);
    fork
      begin send(0, 1, 'h20, 1'b1); send(0, 1, 'h24, 1'b1); end
      send(1, 1, 'h21, 1'b1);
      send(2, 1, 'h22, 1'b1);
      send(3, 1, 'h23, 1'b1);
    join

    // backpressure on req2: 4 stalled cycles after 2 beats
    exp_beats(2, 6, 'h30);
    gnt_q.push_back(2);
    fork
      send(2, 6, 'h30, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 full_drv = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("s3_stall_wr_en", 32'(wr_en_o), 0);
          chk("s3_stall_ready", 32'(req_ready_o), 0);
          chk("s3_stall_grant", 32'(grant_o), 'b0100);
        end
        @(posedge clk);
        #1 full_drv = 1'b0;
      end
    join

    // burst cap: req1 streams 12 beats, req3 slips in after beat 8
    exp_beats(1, 8, 'h40);
    exp_beats(3, 1, 'h50);
    exp_beats(1, 4, 'h48);
    gnt_q.push_back(1); gnt_q.push_back(3); gnt_q.push_back(1);
    fork
      send(1, 12, 'h40, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        send(3, 1, 'h50, 1'b1);
      end
    join
    repeat (3) begin
      @(negedge clk);
      chk("s4_hold_grant", 32'(grant_o), 'b0010);
      chk("s4_hold_busy", 32'(busy_o), 1);
    end
    pulse_reset();
    @(negedge clk);
    chk("s4_reset_grant", 32'(grant_o), 0);

    // reset mid-burst of req0 after req1 moved last_owner to 1
    exp_q.push_back('h15F);
    gnt_q.push_back(1);
    send(1, 1, 'h5F, 1'b1);
    exp_beats(0, 4, 'h60);
    exp_beats(2, 1, 'h70);
    gnt_q.push_back(0); gnt_q.push_back(0); gnt_q.push_back(2);
    fork
      send(0, 4, 'h60, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #1;
        send(2, 1, 'h70, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("s5_rst_wr_en", 32'(wr_en_o), 0);
        chk("s5_rst_ready", 32'(req_ready_o), 0);
        chk("s5_rst_data", 32'(data_o), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("s5_post_rst_grant", 32'(grant_o), 0);
        chk("s5_post_rst_busy", 32'(busy_o), 0);
      end
    join

    // loopback through a small FIFO drained by a slower read clock
    lb_mode = 1'b1;
    exp_beats(0, 2, 'h80);
    exp_beats(1, 2, 'h90);
    exp_beats(0, 2, 'h82);
    exp_beats(1, 2, 'h92);
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
    fork
      begin send(0, 2, 'h80, 1'b1); send(0, 2, 'h82, 1'b1); end
      begin send(1, 2, 'h90, 1'b1); send(1, 2, 'h92, 1'b1); end
    join
    t = 0;
    while (rd_ptr < 8 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk("lb_count", 32'(rd_ptr), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < rd_ptr) chk("lb_data", 32'(rb_data[i]), 32'(lb_exp[i]));
    end

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("grants_drained", 32'(gnt_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
